// File: rtl/game_pkt_pkg.sv
// Shared definitions for game packets: field widths and offsets, the clear-command ID, screen bounds,
// and an unpack helper for the decoder, the renderer and the UART test top.
package game_pkt_pkg;

  localparam int ID_W    = 8;
  localparam int COORD_W = 16;
  localparam int PKT_W   = ID_W + 2 * COORD_W;
  localparam int ID_LSB  = 2 * COORD_W;
  localparam int X_LSB   = COORD_W;
  localparam int Y_LSB   = 0;

  localparam logic [ID_W-1:0]    CLEAR_ID = '0;
  localparam logic [COORD_W-1:0] X_MAX    = 16'd639;
  localparam logic [COORD_W-1:0] Y_MAX    = 16'd479;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pkt_t;

  function automatic pkt_t unpack_pkt(input logic [PKT_W-1:0] p);
    pkt_t f;
    f.id = p[ID_LSB +: ID_W];
    f.x  = p[X_LSB +: COORD_W];
    f.y  = p[Y_LSB +: COORD_W];
    return f;
  endfunction

endpackage

// File: rtl/led_pulse_stretch.sv
// Stretches a one-cycle trigger into an ACT_CYC-cycle high level; a trigger while high restarts the count.
module led_pulse_stretch #(
  parameter int ACT_CYC = 2500000
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic trig,
  output logic out
);

  localparam int CW = $clog2(ACT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (trig) begin
      cnt <= CW'(ACT_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign out = (cnt != '0);

endmodule

// File: rtl/game_packet_decoder.sv
// Two-stage game packet decoder: registers the strobed packet, then clears, writes (with clamping)
// or rejects it, keeping a position table, saturating error counters and a status LED byte.
module game_packet_decoder #(
  parameter int                          ID_W     = game_pkt_pkg::ID_W,
  parameter int                          COORD_W  = game_pkt_pkg::COORD_W,
  parameter int                          NUM_ELEM = 8,
  parameter logic [COORD_W-1:0]          X_MAX    = COORD_W'(game_pkt_pkg::X_MAX),
  parameter logic [COORD_W-1:0]          Y_MAX    = COORD_W'(game_pkt_pkg::Y_MAX),
  parameter int                          ACT_CYC  = 2500000,
  parameter int                          CNT_W    = 8,
  localparam int                         PKT_W    = ID_W + 2 * COORD_W,
  localparam int                         IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
  input  logic               clk50,
  input  logic               rst_n,
  // pkt_valid is a one-cycle strobe with no back-pressure: packet is sampled only in that cycle,
  // and a strobe may arrive every cycle.
  input  logic [PKT_W-1:0]   packet,
  input  logic               pkt_valid,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               rd_vld,
  output logic               upd_pulse,
  output logic [IDX_W-1:0]   upd_idx,
  output logic [CNT_W-1:0]   bad_id_cnt,
  output logic [CNT_W-1:0]   clamp_cnt,
  output logic [7:0]         leds
);

  import game_pkt_pkg::*;

  logic               run;
  logic               s1_vld;
  logic [PKT_W-1:0]   s1_pkt;
  logic [ID_W-1:0]    s1_id;
  logic [COORD_W-1:0] s1_x, s1_y, x_cl, y_cl;
  logic               x_over, y_over;
  logic               is_clear, is_write, is_bad;
  logic [IDX_W-1:0]   wr_idx;

  logic [COORD_W-1:0] tab_x [NUM_ELEM];
  logic [COORD_W-1:0] tab_y [NUM_ELEM];
  logic [NUM_ELEM-1:0] tab_v;

  logic               bad_sticky, clamp_sticky, act;
  logic [4:0]         last_idx;

  assign s1_id = s1_pkt[2*COORD_W +: ID_W];
  assign s1_x  = s1_pkt[COORD_W +: COORD_W];
  assign s1_y  = s1_pkt[0 +: COORD_W];

  always_comb begin
    is_clear = s1_vld && (s1_id == ID_W'(CLEAR_ID));
    is_write = s1_vld && (s1_id != ID_W'(CLEAR_ID)) && (s1_id <= ID_W'(NUM_ELEM));
    is_bad   = s1_vld && (s1_id > ID_W'(NUM_ELEM));
    wr_idx   = IDX_W'(s1_id - ID_W'(1));
    x_over   = (s1_x > X_MAX);
    y_over   = (s1_y > Y_MAX);
    x_cl     = x_over ? X_MAX : s1_x;
    y_cl     = y_over ? Y_MAX : s1_y;
  end

  // run stays low through the first edge after reset release so a strobe there is dropped.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      s1_vld <= 1'b0;
      s1_pkt <= '0;
    end else begin
      run    <= 1'b1;
      s1_vld <= pkt_valid && run;
      if (pkt_valid) s1_pkt <= packet;
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        tab_x[i] <= '0;
        tab_y[i] <= '0;
      end
      tab_v <= '0;
    end else if (is_clear) begin
      tab_v <= '0;
    end else if (is_write) begin
      tab_x[wr_idx] <= x_cl;
      tab_y[wr_idx] <= y_cl;
      tab_v[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      upd_pulse    <= 1'b0;
      upd_idx      <= '0;
      last_idx     <= '0;
      bad_id_cnt   <= '0;
      clamp_cnt    <= '0;
      bad_sticky   <= 1'b0;
      clamp_sticky <= 1'b0;
    end else begin
      upd_pulse <= is_write;
      if (is_write) begin
        upd_idx  <= wr_idx;
        last_idx <= 5'(wr_idx);
      end
      if (is_bad) begin
        bad_sticky <= 1'b1;
        if (bad_id_cnt != '1) bad_id_cnt <= bad_id_cnt + CNT_W'(1);
      end
      // One count per packet even when both axes were clamped.
      if (is_write && (x_over || y_over)) begin
        clamp_sticky <= 1'b1;
        if (clamp_cnt != '1) clamp_cnt <= clamp_cnt + CNT_W'(1);
      end
    end
  end

  // Registered read sees the table before any write landing on the same edge.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      rd_x   <= '0;
      rd_y   <= '0;
      rd_vld <= 1'b0;
    end else if (32'(rd_idx) < NUM_ELEM) begin
      rd_x   <= tab_x[rd_idx];
      rd_y   <= tab_y[rd_idx];
      rd_vld <= tab_v[rd_idx];
    end else begin
      rd_x   <= '0;
      rd_y   <= '0;
      rd_vld <= 1'b0;
    end
  end

  led_pulse_stretch #(.ACT_CYC(ACT_CYC)) u_act (
    .clk50 (clk50),
    .rst_n (rst_n),
    .trig  (upd_pulse),
    .out   (act)
  );

  assign leds = {bad_sticky, clamp_sticky, act, last_idx};

endmodule

// File: tb/tb_game_packet_decoder.sv
// Directed bench for game_packet_decoder: a driver pushes expected updates into a queue and a
// monitor pops and checks them against every upd_pulse, with directed checks of table, counters and LEDs.
module tb_game_packet_decoder;

  localparam int IDX_W = 3;
  localparam int EXP_W = IDX_W + 32;

  logic        clk50 = 1'b0;
  logic        rst_n;
  logic [39:0] packet;
  logic        pkt_valid;
  logic [2:0]  rd_idx;
  logic [15:0] rd_x, rd_y;
  logic        rd_vld, upd_pulse;
  logic [2:0]  upd_idx;
  logic [7:0]  bad_id_cnt, clamp_cnt, leds;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] cyc = '0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;

  logic [15:0] mx [8];
  logic [15:0] my [8];
  logic [7:0]  mv;
  int          exp_bad, exp_clamp;
  logic [4:0]  exp_last;

  game_packet_decoder #(.NUM_ELEM(8), .ACT_CYC(10), .CNT_W(8)) dut (
    .clk50(clk50), .rst_n(rst_n), .packet(packet), .pkt_valid(pkt_valid), .rd_idx(rd_idx),
    .rd_x(rd_x), .rd_y(rd_y), .rd_vld(rd_vld), .upd_pulse(upd_pulse), .upd_idx(upd_idx),
    .bad_id_cnt(bad_id_cnt), .clamp_cnt(clamp_cnt), .leds(leds)
  );

  // clock / cycle counter
  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mx[i] = '0;
      my[i] = '0;
    end
    mv = '0;
    exp_bad = 0;
    exp_clamp = 0;
    exp_last = '0;
    exp_q.delete();
  endtask

  // Drive a strobe in the current cycle and record what the spec says must follow.
  task automatic drive(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y);
    logic [2:0] idx;
    packet = {id, x, y};
    pkt_valid = 1'b1;
    if (id == 8'd0) begin
      mv = '0;
    end else if (id <= 8'd8) begin
      idx = 3'(id - 8'd1);
      mx[idx] = (x > 16'd639) ? 16'd639 : x;
      my[idx] = (y > 16'd479) ? 16'd479 : y;
      mv[idx] = 1'b1;
      if ((x > 16'd639 || y > 16'd479) && exp_clamp < 255) exp_clamp++;
      exp_last = 5'(idx);
      exp_q.push_back({idx, cyc + 32'd2});
    end else if (exp_bad < 255) begin
      exp_bad++;
    end
  endtask

  task automatic send(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk50);
    drive(id, x, y);
  endtask

  task automatic flush();
    @(negedge clk50);
    pkt_valid = 1'b0;
    repeat (4) @(negedge clk50);
  endtask

  task automatic read_chk(input string name, input logic [2:0] idx, input logic [15:0] ex,
                          input logic [15:0] ey, input logic ev);
    @(negedge clk50);
    rd_idx = idx;
    @(negedge clk50);
    chk(name, {rd_vld, rd_x, rd_y}, {ev, ex, ey});
  endtask

  // scoreboard monitor
  always @(negedge clk50) begin
    if (rst_n) begin
      if (upd_pulse) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL upd_unexpected: got pulse idx %0d at cycle %0d, expected none", upd_idx, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("upd_idx", 64'(upd_idx), 64'(mon_e[EXP_W-1:32]));
          chk("upd_cycle", 64'(cyc), 64'(mon_e[31:0]));
        end
      end else if (exp_q.size() > 0 && exp_q[0][31:0] <= cyc) begin
        mon_e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL upd_missing: got no pulse by cycle %0d, expected idx %0d", cyc, mon_e[EXP_W-1:32]);
      end
    end
  end

  initial begin
    int hi;
    rst_n = 1'b0;
    pkt_valid = 1'b0;
    packet = '0;
    rd_idx = '0;
    model_reset();
    #1;
    chk("reset_outputs", {rd_x, rd_y, rd_vld, upd_pulse, upd_idx, bad_id_cnt, clamp_cnt, leds}, '0);
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    repeat (2) @(negedge clk50);

    // basic write
    send(8'd1, 16'd100, 16'd200);
    flush();
    chk("t1_leds", leds, 8'b0010_0000);
    read_chk("t1_read0", 3'd0, 16'd100, 16'd200, 1'b1);

    // out-of-range ID
    send(8'd9, 16'd5, 16'd5);
    flush();
    chk("t2_bad_cnt", bad_id_cnt, 8'd1);
    chk("t2_led7", leds[7], 1'b1);
    chk("t2_led_idx", leds[4:0], 5'd0);
    read_chk("t2_read0", 3'd0, 16'd100, 16'd200, 1'b1);

    // clamping, both axes then boundary values
    send(8'd3, 16'h2031, 16'd500);
    flush();
    chk("t3_clamp_cnt", clamp_cnt, 8'd1);
    chk("t3_leds", leds, 8'b1110_0010);
    read_chk("t3_read2", 3'd2, 16'd639, 16'd479, 1'b1);
    send(8'd4, 16'd639, 16'd479);
    send(8'd5, 16'd640, 16'd0);
    flush();
    chk("t3_clamp_edges", clamp_cnt, 8'd2);
    read_chk("t3_read3", 3'd3, 16'd639, 16'd479, 1'b1);
    read_chk("t3_read4", 3'd4, 16'd639, 16'd0, 1'b1);

    // back-to-back IDs 1..8 then clear
    for (int i = 1; i <= 8; i++) send(8'(i), 16'(i * 10), 16'(i * 20));
    send(8'd0, 16'd1, 16'd1);
    flush();
    chk("t4_leds", leds, 8'b1110_0111);
    chk("t4_bad_cnt", bad_id_cnt, 8'd1);
    chk("t4_clamp_cnt", clamp_cnt, 8'd2);
    for (int i = 0; i < 8; i++) read_chk("t4_cleared", 3'(i), 16'((i + 1) * 10), 16'((i + 1) * 20), 1'b0);

    // read-before-write on the same entry
    rd_idx = 3'd0;
    send(8'd1, 16'd7, 16'd8);
    @(negedge clk50);
    pkt_valid = 1'b0;
    @(negedge clk50);
    chk("rbw_old", {rd_vld, rd_x, rd_y}, {1'b0, 16'd10, 16'd20});
    @(negedge clk50);
    chk("rbw_new", {rd_vld, rd_x, rd_y}, {1'b1, 16'd7, 16'd8});

    // bad-ID counter saturation
    for (int i = 0; i < 300; i++) send(8'd200, 16'd1, 16'd1);
    flush();
    chk("t5_bad_sat", bad_id_cnt, 64'(exp_bad));
    chk("t5_bad_255", bad_id_cnt, 8'd255);
    chk("t5_leds", leds, 8'b1100_0000);

    // async reset with a packet in stage 1, strobe held across release
    send(8'd1, 16'd1, 16'd1);
    @(posedge clk50);
    #3;
    rst_n = 1'b0;
    pkt_valid = 1'b0;
    #1;
    chk("t6_async_reset", {rd_x, rd_y, rd_vld, upd_pulse, upd_idx, bad_id_cnt, clamp_cnt, leds}, '0);
    model_reset();
    packet = {8'd1, 16'd3, 16'd4};
    pkt_valid = 1'b1;
    repeat (2) @(negedge clk50);
    rst_n = 1'b1;
    @(negedge clk50);
    pkt_valid = 1'b0;
    repeat (4) @(negedge clk50);
    read_chk("t6_no_write", 3'd0, 16'd0, 16'd0, 1'b0);
    chk("t6_counters", {bad_id_cnt, clamp_cnt, leds}, '0);

    // activity stretch: two updates 5 cycles apart
    hi = 0;
    send(8'd1, 16'd50, 16'd60);
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk50);
      if (t == 1) pkt_valid = 1'b0;
      if (t == 5) drive(8'd2, 16'd70, 16'd80);
      if (t == 6) pkt_valid = 1'b0;
      if (leds[5]) hi++;
    end
    chk("t7_act_cycles", 64'(hi), 64'd15);
    chk("t7_led_idx", leds[4:0], exp_last);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_packet_decoder.md
Name: game_packet_decoder

Overview:
- Consumes 40-bit game packets {element ID, x_pos, y_pos} from the UART packet receiver, qualified by a one-cycle strobe.
- Maintains a position table of NUM_ELEM game elements, enforces ID and coordinate rules, and counts rejected packets.
- Drives a status LED byte.
- Sits between the UART receiver and the display renderer; the renderer reads the table through a registered read port.

Parameters:
- ID_W, 8, element ID width.
- COORD_W, 16, width of each of x_pos and y_pos.
- NUM_ELEM, 8, table entries; valid IDs are 1..NUM_ELEM, with 1 <= NUM_ELEM <= 2^ID_W-1.
- X_MAX, 16'd639, largest legal x coordinate.
- Y_MAX, 16'd479, largest legal y coordinate.
- ACT_CYC, 2500000, activity LED stretch length in clk50 cycles (50 ms).
- CNT_W, 8, width of the error counters.

Ports:
- clk50  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- packet  in  ID_W+2*COORD_W  {id[ID_W+2*COORD_W-1:2*COORD_W], x[2*COORD_W-1:COORD_W], y[COORD_W-1:0]}.
- pkt_valid  in  1  one-cycle strobe; packet is valid only in that cycle.
- rd_idx  in  clog2(NUM_ELEM)  table read index (0-based; entry i holds ID i+1).
- rd_x  out  COORD_W  x of entry rd_idx, registered.
- rd_y  out  COORD_W  y of entry rd_idx, registered.
- rd_vld  out  1  entry written since last clear, registered.
- upd_pulse  out  1  one-cycle pulse when an entry is written.
- upd_idx  out  clog2(NUM_ELEM)  index written, valid with upd_pulse.
- bad_id_cnt  out  CNT_W  saturating count of rejected IDs.
- clamp_cnt  out  CNT_W  saturating count of clamped coordinates.
- leds  out  8  status byte.

Behaviour:
- Reset: all outputs 0, table x/y/valid cleared, counters 0, stretch counter 0; takes effect asynchronously, mid-packet included. A packet strobed in the reset-release cycle is ignored.
- Pipeline stage 1, on pkt_valid: register packet and set s1_vld.
- Pipeline stage 2, on s1_vld, classify the registered ID:
  - ID == 0: clear command. All table valid bits go to 0; x/y are retained; no upd_pulse; counters unchanged.
  - ID in 1..NUM_ELEM: write entry ID-1. Store clamped x = min(x, X_MAX) and clamped y = min(y, Y_MAX) (unsigned), then set valid=1. Assert upd_pulse and upd_idx. If either coordinate was clamped, clamp_cnt increments once per packet, not once per axis.
  - ID > NUM_ELEM: no table change; bad_id_cnt increments.
- Latency: pkt_valid in cycle N gives table write, upd_pulse and counter update in cycle N+2.
- Back-to-back strobes, one per cycle, are all processed in order; no packet is dropped.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Read port: rd_x/rd_y/rd_vld in cycle N+1 reflect table contents at the end of cycle N for the rd_idx sampled in cycle N. A write to the same entry in cycle N is visible at cycle N+2 (read-before-write).
- rd_idx >= NUM_ELEM returns 0/0/0.
- leds[7]: bad-ID sticky; set on the first rejected ID, cleared only by reset.
- leds[6]: clamp sticky; same rules as leds[7].
- leds[5]: activity. High for ACT_CYC cycles after each upd_pulse; a new upd_pulse while high reloads the counter.
- leds[4:0]: upd_idx of the last successful write, zero-extended or truncated; 0 after reset.
- leds[4:0] are not changed by a clear command.

Decomposition:
- Shared package game_pkt_pkg: ID_W, COORD_W, packet field offsets, the CLEAR_ID=0 constant, screen bounds X_MAX/Y_MAX, and a function that extracts id/x/y from the packet, for reuse by the renderer and the UART test top.
- One sub-module: led_pulse_stretch (parameter ACT_CYC; ports clk50, rst_n, trig, out) for leds[5].
- Table, classifier and counters stay in the top module.

Test Plan:
- Reset, then packet {8'd1,16'd100,16'd200} strobed at cycle N -> upd_pulse at N+2 with upd_idx=0. Reading rd_idx=0 returns 100/200/vld=1. leds=8'b0010_0000.
- Packet {8'd9,16'd5,16'd5} with NUM_ELEM=8 -> no upd_pulse; bad_id_cnt=1; leds[7]=1; table unchanged.
- Packet {8'd3,16'h2031,16'd500} -> entry 2 holds x=639, y=479; clamp_cnt=1 (one count for two axes); leds[6]=1; leds[4:0]=2.
- Write IDs 1..8 on consecutive cycles, then ID 0 -> all 8 upd_pulses in order; then rd_vld=0 for every index while x/y are retained; counters unchanged.
- 300 strobes of ID 200 with CNT_W=8 -> bad_id_cnt saturates at 255.
- Assert rst_n low while a packet sits in stage 1 -> all outputs 0 immediately; no write after release. With ACT_CYC=10, two updates 5 cycles apart -> leds[5] high for 15 cycles.
